// File: rtl/bram_stream_dma_pkg.sv
// Shared definitions for the block-RAM stream sequencer.
// Holds the default address/data widths and the sequencer state encoding.
package bram_stream_dma_pkg;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      StIdle,
      StWr,
      StRd,
      StFin
   } state_e;

endpackage

// File: rtl/bram_addr_gen.sv
// Wrapping word pointer plus remaining-word counter for one transfer.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load_i          capture base_i / saturated len_i
//   step_i          one beat done: ptr+1 (mod depth), remaining-1
//   base_i, len_i   start address and requested word count
//   ptr_o           current RAM address
//   last_o          exactly one word left
//   empty_o         no words left
module bram_addr_gen
   import bram_stream_dma_pkg::*;
#(
   parameter int unsigned AddrW = ADDR_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [AddrW-1:0] base_i,
   input  logic [AddrW:0]   len_i,
   output logic [AddrW-1:0] ptr_o,
   output logic             last_o,
   output logic             empty_o
);

   localparam logic [AddrW:0] MaxLen = {1'b1, {AddrW{1'b0}}};

   logic [AddrW-1:0] ptr_q, ptr_d;
   logic [AddrW:0]   rem_q, rem_d;
   logic [AddrW:0]   len_sat;

   // Requests beyond the RAM depth are clipped to one full pass.
   assign len_sat = (len_i > MaxLen) ? MaxLen : len_i;

   always_comb begin
      ptr_d = ptr_q;
      rem_d = rem_q;
      if (load_i) begin
         ptr_d = base_i;
         rem_d = len_sat;
      end else if (step_i) begin
         ptr_d = ptr_q + AddrW'(1);
         rem_d = rem_q - (AddrW + 1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         rem_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         rem_q <= rem_d;
      end
   end

   assign ptr_o   = ptr_q;
   assign last_o  = (rem_q == (AddrW + 1)'(1));
   assign empty_o = (rem_q == '0);

endmodule

// File: rtl/bram_stream_dma.sv
// Sequencer in front of a single-port block RAM with combinational read data.
// Write mode loads a valid/ready input stream into consecutive words; read mode streams a
// word range out over valid/ready. One transfer at a time.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   start_wr_i, start_rd_i           start pulses (write wins when both are high)
//   base_addr_i, length_i            first word and word count (saturates at depth)
//   s_valid_i, s_ready_o, s_data_i   input stream
//   m_valid_o, m_ready_i, m_data_o   output stream (registered)
//   busy_o, done_o                   transfer active / one-cycle completion pulse
//   bram_we_o, bram_addr_o, bram_din_o, bram_dout_i   RAM port
module bram_stream_dma
   import bram_stream_dma_pkg::*;
#(
   parameter int unsigned AddrW = ADDR_W,
   parameter int unsigned DataW = DATA_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_wr_i,
   input  logic             start_rd_i,
   input  logic [AddrW-1:0] base_addr_i,
   input  logic [AddrW:0]   length_i,
   input  logic             s_valid_i,
   output logic             s_ready_o,
   input  logic [DataW-1:0] s_data_i,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic [DataW-1:0] m_data_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             bram_we_o,
   output logic [AddrW-1:0] bram_addr_o,
   output logic [DataW-1:0] bram_din_o,
   input  logic [DataW-1:0] bram_dout_i
);

   state_e           state_q, state_d;
   logic             m_valid_q, m_valid_d;
   logic [DataW-1:0] m_data_q, m_data_d;
   logic             load, step, last, empty;

   bram_addr_gen #(
      .AddrW(AddrW)
   ) u_addr_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load),
      .step_i (step),
      .base_i (base_addr_i),
      .len_i  (length_i),
      .ptr_o  (bram_addr_o),
      .last_o (last),
      .empty_o(empty)
   );

   always_comb begin
      state_d    = state_q;
      m_valid_d  = m_valid_q;
      m_data_d   = m_data_q;
      load       = 1'b0;
      step       = 1'b0;
      s_ready_o  = 1'b0;
      bram_we_o  = 1'b0;
      bram_din_o = '0;
      done_o     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_wr_i) begin
               load    = 1'b1;
               state_d = (length_i == '0) ? StFin : StWr;
            end else if (start_rd_i) begin
               load    = 1'b1;
               state_d = (length_i == '0) ? StFin : StRd;
            end
         end
         StWr: begin
            s_ready_o  = 1'b1;
            bram_we_o  = s_valid_i;
            bram_din_o = s_data_i;
            if (s_valid_i) begin
               step = 1'b1;
               if (last) state_d = StFin;
            end
         end
         StRd: begin
            // Output register refills whenever it is empty or being drained this cycle.
            if ((!m_valid_q || m_ready_i) && !empty) begin
               m_data_d  = bram_dout_i;
               m_valid_d = 1'b1;
               step      = 1'b1;
            end else if (m_valid_q && m_ready_i) begin
               // Final word accepted with nothing left to fetch.
               m_valid_d = 1'b0;
               state_d   = StFin;
            end
         end
         StFin: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
      end
   end

   assign busy_o    = (state_q != StIdle);
   assign m_valid_o = m_valid_q;
   assign m_data_o  = m_data_q;

endmodule

// File: tb/tb_bram_stream_dma.sv
module tb_bram_stream_dma;
   localparam int unsigned AW    = 10;
   localparam int unsigned DW    = 32;
   localparam int unsigned Depth = 1024;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_wr = 1'b0, start_rd = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic          s_valid = 1'b0, s_ready;
   logic [DW-1:0] s_data = '0;
   logic          m_valid, m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          busy, done, bram_we;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_din, bram_dout;

   always #5 clk = ~clk;

   bram_stream_dma dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_wr_i (start_wr),
      .start_rd_i (start_rd),
      .base_addr_i(base_addr),
      .length_i   (length),
      .s_valid_i  (s_valid),
      .s_ready_o  (s_ready),
      .s_data_i   (s_data),
      .m_valid_o  (m_valid),
      .m_ready_i  (m_ready),
      .m_data_o   (m_data),
      .busy_o     (busy),
      .done_o     (done),
      .bram_we_o  (bram_we),
      .bram_addr_o(bram_addr),
      .bram_din_o (bram_din),
      .bram_dout_i(bram_dout)
   );

   // Block RAM: synchronous write, combinational read.
   logic [DW-1:0] ram [Depth];
   always @(posedge clk) if (bram_we) ram[bram_addr] <= bram_din;
   assign bram_dout = ram[bram_addr];

   // Reference memory: what the RAM must hold after the transfers issued so far.
   logic [DW-1:0] ref_mem [Depth];
   bit            ref_vld [Depth];

   int n_checks = 0;
   int n_errors = 0;
   int done_seen = 0;
   bit gap_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   always @(negedge clk) if (done) done_seen++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat_len(input int len);
      return (len > Depth) ? Depth : len;
   endfunction

   // gap_mode: 0 = s_valid held, 1 = pattern 1,0,1,1, 2 = random.
   task automatic do_write(input int base, input int len, input logic [DW-1:0] data[$],
                           input int gap_mode, input bit both, input bit noise);
      int n, beats, cyc;
      bit v;
      n = sat_len(len);
      beats = 0;
      cyc = 0;
      @(negedge clk);
      start_wr = 1'b1;
      start_rd = both;
      base_addr = AW'(base);
      length = (AW + 1)'(len);
      @(posedge clk);
      if (n == 0) begin
         @(negedge clk);
         start_wr = 1'b0;
         start_rd = 1'b0;
         #1;
         check("wr0_done", done, 1);
         check("wr0_we", bram_we, 0);
         check("wr0_ready", s_ready, 0);
      end else begin
         while (beats < n && cyc < 4 * n + 20) begin
            @(negedge clk);
            start_wr = 1'b0;
            start_rd = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            case (gap_mode)
               0:       v = 1'b1;
               1:       v = gap_pat[cyc % 4];
               default: v = 1'($urandom_range(0, 1));
            endcase
            s_valid = v;
            s_data = v ? data[beats] : $urandom;
            #1;
            check("wr_busy", busy, 1);
            check("wr_s_ready", s_ready, 1);
            check("wr_we", bram_we, v);
            check("wr_m_valid", m_valid, 0);
            if (v) begin
               check("wr_addr", bram_addr, (base + beats) % Depth);
               check("wr_din", bram_din, data[beats]);
               ref_mem[(base + beats) % Depth] = data[beats];
               ref_vld[(base + beats) % Depth] = 1'b1;
               beats++;
            end
            cyc++;
         end
         if (beats < n) check("wr_timeout", beats, n);
         @(negedge clk);
         s_valid = 1'b0;
         start_rd = 1'b0;
         #1;
         check("wr_done", done, 1);
         check("wr_fin_we", bram_we, 0);
         check("wr_fin_ready", s_ready, 0);
      end
      @(negedge clk);
      #1;
      check("wr_idle_busy", busy, 0);
      check("wr_idle_done", done, 0);
      check("wr_idle_m_valid", m_valid, 0);
   endtask

   // rmode: 0 = m_ready held, 1 = pattern 1,0,0,1, 2 = random.
   task automatic do_read(input int base, input int len, input int rmode);
      int n, idx, cyc;
      bit held;
      logic [DW-1:0] prev;
      n = sat_len(len);
      idx = 0;
      cyc = 0;
      held = 1'b0;
      prev = '0;
      @(negedge clk);
      start_rd = 1'b1;
      base_addr = AW'(base);
      length = (AW + 1)'(len);
      @(posedge clk);
      @(negedge clk);
      start_rd = 1'b0;
      if (n == 0) begin
         #1;
         check("rd0_done", done, 1);
         check("rd0_m_valid", m_valid, 0);
      end else begin
         while (idx < n && cyc < 8 * n + 20) begin
            case (rmode)
               0:       m_ready = 1'b1;
               1:       m_ready = rdy_pat[cyc % 4];
               default: m_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            check("rd_busy", busy, 1);
            check("rd_we", bram_we, 0);
            if (held) begin
               check("rd_hold_valid", m_valid, 1);
               check("rd_hold_data", m_data, prev);
            end
            if (m_valid && m_ready) begin
               check("rd_data", m_data, ref_mem[(base + idx) % Depth]);
               idx++;
               held = 1'b0;
            end else begin
               held = m_valid;
            end
            prev = m_data;
            cyc++;
            @(negedge clk);
         end
         if (idx < n) check("rd_timeout", idx, n);
         if (rmode == 0) check("rd_cycles", cyc, n + 1);
         m_ready = 1'b0;
         #1;
         check("rd_done", done, 1);
         check("rd_fin_m_valid", m_valid, 0);
      end
      @(negedge clk);
      #1;
      check("rd_idle_busy", busy, 0);
      check("rd_idle_done", done, 0);
      check("rd_idle_m_valid", m_valid, 0);
   endtask

   initial begin
      logic [DW-1:0] q[$];
      int base, len, d0, d1;

      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_we", bram_we, 0);
      check("rst_m_data", m_data, 0);
      check("rst_addr", bram_addr, 0);
      check("rst_din", bram_din, 0);
      rst_n = 1'b1;

      // Wrapping write and readback.
      q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      do_write(10'h3FE, 4, q, 0, 1'b0, 1'b0);
      do_read(10'h3FE, 4, 0);
      do_read(10'h3FE, 4, 1);

      // Gapped write, then readback under backpressure.
      q.delete();
      for (int i = 0; i < 12; i++) q.push_back($urandom);
      do_write(100, 12, q, 1, 1'b0, 1'b0);
      do_read(100, 12, 1);

      // Both starts together, then start_rd noise while busy.
      q.delete();
      for (int i = 0; i < 9; i++) q.push_back($urandom);
      do_write(500, 9, q, 0, 1'b1, 1'b1);
      do_read(500, 9, 2);

      // Random transfers.
      for (int t = 0; t < 6; t++) begin
         base = $urandom_range(0, Depth - 1);
         len = $urandom_range(1, 40);
         q.delete();
         for (int i = 0; i < len; i++) q.push_back($urandom);
         do_write(base, len, q, 2, 1'b0, 1'b0);
         do_read((base + $urandom_range(0, len - 1)) % Depth, $urandom_range(1, len), 2);
      end

      // Oversized length saturates to one full pass of the RAM.
      base = $urandom_range(0, Depth - 1);
      q.delete();
      for (int i = 0; i < Depth; i++) q.push_back($urandom);
      do_write(base, 2047, q, 0, 1'b0, 1'b0);
      do_read($urandom_range(0, Depth - 1), 1025, 2);

      // Zero-length transfers.
      q.delete();
      do_write(7, 0, q, 0, 1'b0, 1'b0);
      do_read(7, 0, 0);

      // Reset during beat 2 of an 8-word write.
      base = $urandom_range(0, Depth - 1);
      q.delete();
      for (int i = 0; i < 8; i++) q.push_back($urandom);
      @(negedge clk);
      start_wr = 1'b1;
      base_addr = AW'(base);
      length = 11'd8;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         start_wr = 1'b0;
         s_valid = 1'b1;
         s_data = q[i];
         ref_mem[(base + i) % Depth] = q[i];
         ref_vld[(base + i) % Depth] = 1'b1;
      end
      @(negedge clk);
      s_data = q[2];
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_s_ready", s_ready, 0);
      check("arst_m_valid", m_valid, 0);
      check("arst_we", bram_we, 0);
      check("arst_addr", bram_addr, 0);
      check("arst_din", bram_din, 0);
      check("arst_m_data", m_data, 0);
      d0 = done_seen;
      @(negedge clk);
      s_valid = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      d1 = done_seen;
      check("arst_no_done", d1, d0);
      do_read(base, 0, 0);

      // RAM contents against the reference.
      for (int a = 0; a < Depth; a++)
         if (ref_vld[a]) check($sformatf("ram[%0h]", a), ram[a], ref_mem[a]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end
endmodule
